// File: rtl/shiftreg_rotate_sequencer.sv
// Sequencer for a 4-bit universal shift register. It takes one command at a
// time, loads the register, optionally rotates it by feeding DATAOUT back to
// DATAIN, then returns the final contents on a response channel.
module shiftreg_rotate_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_datain,
  input  logic [WIDTH-1:0] sr_dataout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_ROTR  = 2'b01;
  localparam logic [1:0] OP_ROTL  = 2'b10;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROTR = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic is_rot;
  assign is_rot = (op_q == OP_ROTR) || (op_q == OP_ROTL);

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      data_q     <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state logic: command capture, rotation countdown, result capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          count_d = cmd_count;
          state_d = (cmd_op == OP_READ) ? S_CAPTURE : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = count_q;
        state_d = (is_rot && (count_q != '0)) ? S_SHIFT : S_CAPTURE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_data_d = sr_dataout;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register drive, decoded purely from registered state.
  always_comb begin
    sr_mode   = MODE_HOLD;
    sr_datain = '0;
    case (state_q)
      S_LOAD: begin
        sr_mode   = MODE_LOAD;
        sr_datain = data_q;
      end
      S_SHIFT: begin
        sr_mode   = (op_q == OP_ROTL) ? MODE_ROTL : MODE_ROTR;
        sr_datain = sr_dataout;
      end
      default: begin
        sr_mode   = MODE_HOLD;
        sr_datain = '0;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shiftreg_rotate_sequencer.sv
// Bench for the rotate sequencer, closed around a behavioural 4-bit universal
// shift register. Directed table first, then random commands against a model.
module tb_shiftreg_rotate_sequencer;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic [1:0] sr_mode;
  logic [3:0] sr_datain;
  logic [3:0] sr_dataout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] reg_val;

  always #5 clock = ~clock;

  shiftreg_rotate_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .sr_mode    (sr_mode),
    .sr_datain  (sr_datain),
    .sr_dataout (sr_dataout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // Universal shift register: rotates / loads DATAIN, holds on 00.
  logic [3:0] sr_q;
  always_ff @(posedge clock) begin
    if (reset) sr_q <= 4'h0;
    else begin
      case (sr_mode)
        2'b01:   sr_q <= {sr_datain[0], sr_datain[3:1]};
        2'b10:   sr_q <= {sr_datain[2:0], sr_datain[3]};
        2'b11:   sr_q <= sr_datain;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_dataout = sr_q;

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Reference: rotation by n is rotation by n mod 4, computed arithmetically.
  function automatic int model_rsp(logic [1:0] op, int d, int n, int cur);
    int k;
    k = n % 4;
    case (op)
      OP_READ: return cur;
      OP_LOAD: return d;
      OP_ROTR: return ((d >> k) | (d << (4 - k))) & 15;
      default: return ((d << k) | (d >> (4 - k))) & 15;
    endcase
  endfunction

  function automatic int model_lat(logic [1:0] op, int n);
    if (op == OP_READ) return 2;
    if (op == OP_LOAD) return 3;
    return n + 3;
  endfunction

  // Issue one command from a negedge, wait for the response, optionally stall
  // rsp_ready for `hold` cycles while offering another command, then handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] c, input int hold,
                         input logic [3:0] exp_d, input int exp_lat,
                         input string name);
    int g, lat;
    bit got, mode_bad;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clock); g++; end
    if (g == 50) check({name, " ready_timeout"}, 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = ~d;
    cmd_count = 4'($urandom);
    lat = 0; got = 1'b0; mode_bad = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (op == OP_READ && sr_mode != 2'b00) mode_bad = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " rsp_data"}, int'(rsp_data), int'(exp_d));
    if (op == OP_READ) check({name, " read_mode_hold"}, int'(mode_bad), 0);
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check({name, " stall rsp_valid"}, int'(rsp_valid), 1);
        check({name, " stall rsp_data"}, int'(rsp_data), int'(exp_d));
        check({name, " stall cmd_ready"}, int'(cmd_ready), 0);
        check({name, " stall sr_mode"}, int'(sr_mode), 0);
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    check({name, " rsp_valid_drop"}, int'(rsp_valid), 0);
    check({name, " idle_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] cnt;
    int         hold;
    logic [3:0] exp_d;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{OP_LOAD, 4'b1010, 4'd0,  0, 4'b1010, 3};
    vecs[1] = '{OP_ROTR, 4'b1001, 4'd1,  0, 4'b1100, 4};
    vecs[2] = '{OP_ROTL, 4'b0001, 4'd3,  0, 4'b1000, 6};
    vecs[3] = '{OP_ROTR, 4'b1011, 4'd4,  0, 4'b1011, 7};
    vecs[4] = '{OP_ROTR, 4'b1011, 4'd0,  0, 4'b1011, 3};
    vecs[5] = '{OP_READ, 4'b0000, 4'd0,  0, 4'b1011, 2};
    vecs[6] = '{OP_ROTL, 4'b0011, 4'd15, 0, 4'b1001, 18};
    vecs[7] = '{OP_READ, 4'b0110, 4'd5,  0, 4'b1001, 2};
    vecs[8] = '{OP_LOAD, 4'b0110, 4'd0,  5, 4'b0110, 3};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
    cmd_count = 4'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset rsp_valid", int'(rsp_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset sr_mode", int'(sr_mode), 0);
    check("reset sr_datain", int'(sr_datain), 0);
    check("reset rsp_data", int'(rsp_data), 0);
    reset = 1'b0;
    @(negedge clock);
    check("reset cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 9; i++)
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].hold,
              vecs[i].exp_d, vecs[i].lat, $sformatf("vec%0d", i));
    reg_val = 4'b0110;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [3:0] d, c;
      int h;
      logic [3:0] e;
      op = 2'($urandom_range(0, 3));
      d  = 4'($urandom);
      c  = 4'($urandom);
      h  = $urandom_range(0, 2);
      e  = 4'(model_rsp(op, int'(d), int'(c), int'(reg_val)));
      run_cmd(op, d, c, h, e, model_lat(op, int'(c)), $sformatf("rnd%0d", i));
      reg_val = e;
    end

    // Reset in the middle of a long rotation.
    cmd_valid = 1'b1; cmd_op = OP_ROTR; cmd_data = 4'b0101; cmd_count = 4'd10;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("abort busy_in_shift", int'(busy), 1);
    check("abort shifting", int'(sr_mode), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort busy", int'(busy), 0);
    check("abort rsp_valid", int'(rsp_valid), 0);
    check("abort sr_mode", int'(sr_mode), 0);
    reset = 1'b0;
    @(negedge clock);
    check("abort cmd_ready", int'(cmd_ready), 1);
    run_cmd(OP_READ, 4'hA, 4'd3, 0, 4'b0000, 2, "read_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
